sram_phase_sequencer: RTL
=========================

# sram_phase_sequencer

Top-level phase controller and SRAM port owner for the decoder: it sequences UART image load, Milestone 2 (IDCT), Milestone 1 (colour-space conversion) and VGA display, and routes the single SRAM controller port to exactly one requester per phase. It adds a per-phase watchdog, cycle counters and sticky status flags for board bring-up.

## Interface
Parameters:
- UART_TIMEOUT, 50000000: idle-line cycles after the last UART write that end the load phase.
- STAGE_TIMEOUT, 33554432: maximum cycles allowed in M2 or M1 before a fault is declared.

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- UART_RX_I  in  1  raw UART line; a low level detects a start bit.
- restart  in  1  one-cycle pulse (pushbutton) that leaves S_FAULT.
- uart_addr / uart_wdata / uart_we_n  in  18/16/1  UART requester port.
- uart_frame_error  in  1  frame error from the UART receiver.
- m2_addr / m2_wdata / m2_we_n, m2_end  in  18/16/1, 1  M2 requester port and done level.
- m1_addr / m1_wdata / m1_we_n, m1_end  in  18/16/1, 1  M1 requester port and done level.
- vga_addr  in  18  VGA requester address (read-only).
- sram_addr / sram_wdata / sram_we_n  out  18/16/1  port to SRAM_controller.
- uart_initialize, uart_enable  out  1  UART synchronisation pulses.
- m2_start, m1_start  out  1  phase enables, held high for the whole phase.
- vga_enable  out  1  VGA fetch enable.
- done  out  1  one-cycle pulse when M1 completes.
- fault, frame_err_seen  out  1  sticky status flags.
- m2_cycles, m1_cycles  out  32  cycles spent in the last M2 and M1 phases.
- phase  out  3  current state encoding.

## Operation
- States and encodings: S_IDLE=0, S_UART_INIT=1, S_UART_RX=2, S_M2=3, S_M1=4, S_FAULT=5.
- UART_RX_I passes through a 2-flop synchroniser. Only the synchronised value is used.
- S_IDLE: vga_enable=1. When the synchronised RX is 0, the block registers uart_initialize=1 and vga_enable=0, then goes to S_UART_INIT.
- S_UART_INIT: uart_initialize=0, uart_enable=1 for one cycle, then go to S_UART_RX.
- S_UART_RX:
  - A 26-bit silence counter increments every cycle and clears on any cycle with uart_we_n=0.
  - At count UART_TIMEOUT-1 the counter clears and the state goes to S_M2.
  - uart_frame_error=1 sets frame_err_seen. The load still continues.
- S_M2 / S_M1:
  - The matching start is 1 on every cycle in the state.
  - The stage counter clears on entry and increments each cycle.
  - When the matching end is 1, the counter value is latched into m2_cycles or m1_cycles, the start drops the next cycle, and the state advances: M2→M1, M1→IDLE.
  - M1→IDLE also pulses done for one cycle.
  - If the counter reaches STAGE_TIMEOUT-1 without end, go to S_FAULT and set fault.
  - If end and the timeout occur in the same cycle, end wins.
  - An end input from the non-active milestone is ignored.
- S_FAULT: all starts=0, vga_enable=1, sram_we_n forced to 1. A restart pulse returns to S_IDLE. fault stays set until reset.
- SRAM mux (combinational from the registered state only):
  - UART_INIT and UART_RX → uart port.
  - M2 → m2 port.
  - M1 → m1 port.
  - All other states → vga_addr, wdata=0, we_n=1.
- Reset values: state S_IDLE, vga_enable=1, and every other output, counter and flag = 0. sram_we_n=1 through the mux.

## Timing
- Start-bit latency: RX low at edge N → uart_initialize high after edge N+3 (2 for the synchroniser, 1 registered).
- uart_enable rises exactly one cycle after uart_initialize falls.
- Phase outputs are registered. The mux follows the state register with zero added latency, so the SRAM port switches on the same edge the state changes.
- m2_start deasserts and m1_start asserts on the same edge; there is no gap cycle.
- Reset mid-phase: all outputs return to their reset values immediately and asynchronously. Cycle counters and flags clear.
- Counters are 32-bit; stage counters saturate at 2^32-1 (unreachable at the default timeout).

## Test plan
- Reset with UART_TIMEOUT=16 → phase=0, vga_enable=1, sram_we_n=1, sram_addr=vga_addr=18'd146944.
- RX low for 1 cycle, 3 UART writes 5 cycles apart, then silence → uart_initialize pulses once, then uart_enable pulses once; phase=2 until 16 cycles after the last write, then phase=3 and the mux selects m2.
- m2_end asserted 100 cycles after m2_start rises → m2_cycles=99 (counter at end assertion), m1_start high on the next edge; m1_end after 40 cycles → done pulses once, phase=0, m1_cycles=39.
- STAGE_TIMEOUT=64, m2_end never asserted → phase=5 at cycle 64, fault=1, sram_we_n=1; restart pulse → phase=0 with fault still 1.
- m1_end asserted on the same cycle as the timeout → phase=0, done=1, fault=0; m1_end pulsed during S_M2 → ignored.
- uart_frame_error pulse during S_UART_RX, then resetn low during S_M1 → frame_err_seen=1 before the reset; after the reset all flags, counters and starts are 0.

Source files
------------

// File: rtl/sram_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_phase_sequencer: phase FSM (UART load, M2, M1, VGA) and SRAM port mux |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sram_phase_sequencer #(
  parameter int unsigned UART_TIMEOUT  = 50000000,
  parameter int unsigned STAGE_TIMEOUT = 33554432
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        UART_RX_I,
  input  logic        restart,
  input  logic [17:0] uart_addr,
  input  logic [15:0] uart_wdata,
  input  logic        uart_we_n,
  input  logic        uart_frame_error,
  input  logic [17:0] m2_addr,
  input  logic [15:0] m2_wdata,
  input  logic        m2_we_n,
  input  logic        m2_end,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_we_n,
  input  logic        m1_end,
  input  logic [17:0] vga_addr,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we_n,
  output logic        uart_initialize,
  output logic        uart_enable,
  output logic        m2_start,
  output logic        m1_start,
  output logic        vga_enable,
  output logic        done,
  output logic        fault,
  output logic        frame_err_seen,
  output logic [31:0] m2_cycles,
  output logic [31:0] m1_cycles,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UART_INIT = 3'd1,
    S_UART_RX   = 3'd2,
    S_M2        = 3'd3,
    S_M1        = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [25:0] c_uart_last  = 26'(UART_TIMEOUT - 1);
  localparam logic [31:0] c_stage_last = 32'(STAGE_TIMEOUT - 1);

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic [25:0] r_silence;
  logic [31:0] r_stage_cnt;
  logic        r_uart_initialize;
  logic        r_uart_enable;
  logic        r_m2_start;
  logic        r_m1_start;
  logic        r_vga_enable;
  logic        r_done;
  logic        r_fault;
  logic        r_frame_err_seen;
  logic [31:0] r_m2_cycles;
  logic [31:0] r_m1_cycles;

  // Idle UART line is high, so the synchroniser resets to 1.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX_I;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state           <= S_IDLE;
      r_silence         <= '0;
      r_stage_cnt       <= '0;
      r_uart_initialize <= 1'b0;
      r_uart_enable     <= 1'b0;
      r_m2_start        <= 1'b0;
      r_m1_start        <= 1'b0;
      r_vga_enable      <= 1'b1;
      r_done            <= 1'b0;
      r_fault           <= 1'b0;
      r_frame_err_seen  <= 1'b0;
      r_m2_cycles       <= '0;
      r_m1_cycles       <= '0;
    end else begin
      r_done            <= 1'b0;
      r_uart_enable     <= 1'b0;
      r_uart_initialize <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_vga_enable <= 1'b1;
          if (!r_rx_sync) begin
            r_uart_initialize <= 1'b1;
            r_vga_enable      <= 1'b0;
            r_state           <= S_UART_INIT;
          end
        end
        // First cycle lets uart_initialize fall; enable follows a cycle later.
        S_UART_INIT: begin
          r_silence <= '0;
          if (!r_uart_initialize) begin
            r_uart_enable <= 1'b1;
            r_state       <= S_UART_RX;
          end
        end
        S_UART_RX: begin
          if (uart_frame_error) r_frame_err_seen <= 1'b1;
          if (!uart_we_n) begin
            r_silence <= '0;
          end else if (r_silence == c_uart_last) begin
            r_silence   <= '0;
            r_stage_cnt <= '0;
            r_m2_start  <= 1'b1;
            r_state     <= S_M2;
          end else begin
            r_silence <= r_silence + 26'd1;
          end
        end
        S_M2: begin
          if (m2_end) begin
            r_m2_cycles <= r_stage_cnt;
            r_stage_cnt <= '0;
            r_m2_start  <= 1'b0;
            r_m1_start  <= 1'b1;
            r_state     <= S_M1;
          end else if (r_stage_cnt == c_stage_last) begin
            r_m2_start   <= 1'b0;
            r_fault      <= 1'b1;
            r_vga_enable <= 1'b1;
            r_state      <= S_FAULT;
          end else if (r_stage_cnt != '1) begin
            r_stage_cnt <= r_stage_cnt + 32'd1;
          end
        end
        S_M1: begin
          if (m1_end) begin
            r_m1_cycles  <= r_stage_cnt;
            r_stage_cnt  <= '0;
            r_m1_start   <= 1'b0;
            r_done       <= 1'b1;
            r_vga_enable <= 1'b1;
            r_state      <= S_IDLE;
          end else if (r_stage_cnt == c_stage_last) begin
            r_m1_start   <= 1'b0;
            r_fault      <= 1'b1;
            r_vga_enable <= 1'b1;
            r_state      <= S_FAULT;
          end else if (r_stage_cnt != '1) begin
            r_stage_cnt <= r_stage_cnt + 32'd1;
          end
        end
        S_FAULT: begin
          r_m2_start   <= 1'b0;
          r_m1_start   <= 1'b0;
          r_vga_enable <= 1'b1;
          if (restart) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Port ownership follows the state register directly, no added latency.
  always_comb begin
    sram_addr  = vga_addr;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (r_state)
      S_UART_INIT, S_UART_RX: begin
        sram_addr  = uart_addr;
        sram_wdata = uart_wdata;
        sram_we_n  = uart_we_n;
      end
      S_M2: begin
        sram_addr  = m2_addr;
        sram_wdata = m2_wdata;
        sram_we_n  = m2_we_n;
      end
      S_M1: begin
        sram_addr  = m1_addr;
        sram_wdata = m1_wdata;
        sram_we_n  = m1_we_n;
      end
      default: ;
    endcase
  end

  assign uart_initialize = r_uart_initialize;
  assign uart_enable     = r_uart_enable;
  assign m2_start        = r_m2_start;
  assign m1_start        = r_m1_start;
  assign vga_enable      = r_vga_enable;
  assign done            = r_done;
  assign fault           = r_fault;
  assign frame_err_seen  = r_frame_err_seen;
  assign m2_cycles       = r_m2_cycles;
  assign m1_cycles       = r_m1_cycles;
  assign phase           = r_state;

endmodule
`default_nettype wire
